node_eject_receiver: RTL and testbench
======================================

Name: node_eject_receiver

Overview:
- Ejection-side receiver for one oneDimensionalNode in the ring: consumes the node's local output (shiftOutData/shiftOutCS) and delivers packets to the local host.
- Checks each arriving packet's destination field against the node's own IP, buffers accepted packets in a small FIFO, and presents them on a valid/ready interface.
- Keeps saturating statistics for dropped and misrouted packets; sits between the node and host logic, mirroring the injection path.

Parameters:
- NODE_IP, 3'b000, IP of the attached node; compared against packet bits [31:29].
- FIFO_DEPTH, 4, number of packet entries; must be a power of two, at least 2.
- ADDR_W, 2, log2(FIFO_DEPTH).

Ports:
- shiftInCLK  input  1  system clock; all state updates on its rising edge.
- resetN  input  1  asynchronous active-low reset.
- shiftInData  input  32  packet word from node shiftOutData: [31:29] dest IP, [28:26] src IP, [25:0] payload.
- shiftInCS  input  1  from node shiftOutCS; each cycle high = one packet on shiftInData.
- rxData  output  32  head-of-FIFO packet, full word.
- rxSrc  output  3  head packet source IP (= rxData[28:26]).
- rxValid  output  1  FIFO non-empty.
- rxReady  input  1  host pop; a pop occurs when rxValid and rxReady are both high at a clock edge.
- rxFull  output  1  FIFO holds FIFO_DEPTH entries.
- clearStats  input  1  synchronous clear of the counters and the overflow flag.
- dropCount  output  8  saturating count of packets lost to FIFO full.
- misrouteCount  output  8  saturating count of packets whose dest != NODE_IP.
- overflow  output  1  sticky; set on the first drop, cleared only by clearStats or reset.

Behaviour:
- Reset (resetN low, asynchronous): FIFO empty; write and read pointers and occupancy are 0. Outputs: rxValid=0, rxFull=0, rxData=0, rxSrc=0, dropCount=0, misrouteCount=0, overflow=0. While resetN is low, shiftInCS is ignored.
- Each edge with shiftInCS=1 classifies the word:
  - MISROUTE: dest != NODE_IP. Word is not stored; misrouteCount increments, saturating at 255.
  - ACCEPT: dest == NODE_IP and the FIFO has room. Word is written at wrPtr; wrPtr increments and wraps modulo FIFO_DEPTH.
  - DROP: dest == NODE_IP and the FIFO is full with no pop this edge. Word is discarded; dropCount increments, saturating at 255; overflow is set.
- Full plus simultaneous pop: the same-edge pop frees a slot, so the word is ACCEPTed and occupancy stays FIFO_DEPTH.
- Back-to-back packets (shiftInCS high on consecutive cycles) are each classified independently; no gaps are required.
- Latency: a packet accepted at edge N is visible on rxData/rxValid after edge N, i.e. one cycle. The head is shown first-word-fall-through: rxData = mem[rdPtr] whenever rxValid=1, and holds its last value when the FIFO is empty.
- Pop: rdPtr increments and wraps; occupancy decrements. When the FIFO is empty, rxReady has no effect.
- Push and pop on the same edge when not empty: occupancy is unchanged and both pointers advance.
- Push and pop on the same edge when empty: the push lands; the pop is ignored because rxValid was 0.
- Occupancy counter is ADDR_W+1 bits wide. rxFull = (count == FIFO_DEPTH); rxValid = (count != 0).
- clearStats on the same edge as a counting event: the clear wins and the counter ends at 0.
- clearStats does not affect FIFO contents.
- Packet contents are never modified; no parity or CRC checking is performed.
- Reset asserted mid-stream discards all buffered packets immediately. After resetN deasserts, the first shiftInCS edge is processed normally.

Test Plan:
- NODE_IP=000; one-cycle CS with 32'h1092_4924 (dest 000, src 100) -> rxValid rises one cycle later, rxData=32'h1092_4924, rxSrc=3'b100; holding rxReady=1 gives rxValid=0 on the next cycle.
- NODE_IP=000; CS with 32'h4000_0001 (dest 010) -> rxValid stays 0; misrouteCount=1; dropCount=0.
- rxReady=0; five consecutive CS cycles of dest-000 words 32'h0000_0001..32'h0000_0005 -> rxFull=1 after the 4th; dropCount=1; overflow=1; popping yields 1,2,3,4 in order.
- FIFO full, and on the same edge shiftInCS=1 (32'h0000_00AA) with rxReady=1 -> no drop; occupancy stays 4; 32'h0000_00AA emerges as the 4th subsequent pop.
- Force 260 misrouted packets -> misrouteCount saturates at 255. Then pulse clearStats -> misrouteCount=0, dropCount=0, overflow=0, and FIFO contents are unchanged.
- With 2 entries buffered, assert resetN=0 asynchronously between clock edges -> rxValid=0 and rxFull=0 immediately, with no clock edge needed. After release, a new dest-000 packet appears at the head.

Source files
------------

// File: rtl/node_eject_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module   : node_eject_receiver_if
//  Purpose  : Bundles the node-side packet input and the host-side
//             valid/ready delivery port of the ejection receiver.
//  Signals  : shiftInData/shiftInCS - packet word and strobe from the node
//             rxData/rxSrc          - head-of-FIFO packet and its source IP
//             rxValid/rxReady       - host handshake (pop on both high)
//             rxFull                - FIFO holds its full capacity
//  Modports : slave  - the receiver (consumes packets, drives rx side)
//             master - node/host side (drives packets and rxReady)
//  Revision : 1.0 - initial release
// ============================================================================
interface node_eject_receiver_if;
   logic [31:0] shiftInData;
   logic        shiftInCS;
   logic [31:0] rxData;
   logic [2:0]  rxSrc;
   logic        rxValid;
   logic        rxReady;
   logic        rxFull;

   modport slave (
      input  shiftInData, shiftInCS, rxReady,
      output rxData, rxSrc, rxValid, rxFull
   );

   modport master (
      output shiftInData, shiftInCS, rxReady,
      input  rxData, rxSrc, rxValid, rxFull
   );
endinterface
`default_nettype wire

// File: rtl/node_eject_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : node_eject_receiver
//  Purpose  : Ejection-side receiver for one ring node. Classifies every
//             strobed packet word against NODE_IP, buffers local packets in
//             a small first-word-fall-through FIFO and keeps saturating
//             drop/misroute statistics plus a sticky overflow flag.
//  Ports    : shiftInCLK    - clock, rising edge
//             resetN        - asynchronous active-low reset
//             bus (slave)   - packet input and host valid/ready port
//             clearStats    - synchronous clear of counters and overflow
//             dropCount     - saturating count of packets lost to FIFO full
//             misrouteCount - saturating count of packets for other nodes
//             overflow      - sticky, set on the first drop
//  Revision : 1.0 - initial release
// ============================================================================
module node_eject_receiver #(
   parameter logic [2:0] NODE_IP    = 3'b000,
   parameter int         FIFO_DEPTH = 4,
   parameter int         ADDR_W     = 2
) (
   input  wire                     shiftInCLK,
   input  wire                     resetN,
   node_eject_receiver_if.slave    bus,
   input  wire                     clearStats,
   output logic [7:0]              dropCount,
   output logic [7:0]              misrouteCount,
   output logic                    overflow
);

   localparam logic [ADDR_W:0] C_FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0] C_CNT_ONE = (ADDR_W + 1)'(1);

   // Packet storage; no reset needed because occupancy gates visibility.
   logic [31:0] mem_q [FIFO_DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       rx_data_q, rx_data_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic [7:0]        misroute_cnt_q, misroute_cnt_d;
   logic              overflow_q, overflow_d;

   logic is_local;
   logic is_full;
   logic is_valid;
   logic do_pop;
   logic do_push;
   logic do_drop;
   logic do_misroute;

   always_comb begin
      is_local    = (bus.shiftInData[31:29] == NODE_IP);
      is_full     = (count_q == C_FULL_CNT);
      is_valid    = (count_q != '0);
      do_pop      = is_valid && bus.rxReady;
      // A same-edge pop frees a slot, so a full FIFO can still accept.
      do_push     = bus.shiftInCS && is_local && (!is_full || do_pop);
      do_drop     = bus.shiftInCS && is_local && is_full && !do_pop;
      do_misroute = bus.shiftInCS && !is_local;

      wr_ptr_d = do_push ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
      rd_ptr_d = do_pop  ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;

      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + C_CNT_ONE;
      end else if (do_pop && !do_push) begin
         count_d = count_q - C_CNT_ONE;
      end

      // Registered head word. The incoming word becomes the head only when
      // it will be the sole entry, in which case it bypasses the memory.
      rx_data_d = rx_data_q;
      if (count_d != '0) begin
         if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            rx_data_d = bus.shiftInData;
         end else begin
            rx_data_d = mem_q[rd_ptr_d];
         end
      end

      drop_cnt_d     = drop_cnt_q;
      misroute_cnt_d = misroute_cnt_q;
      overflow_d     = overflow_q;
      if (clearStats) begin
         drop_cnt_d     = '0;
         misroute_cnt_d = '0;
         overflow_d     = 1'b0;
      end else begin
         if (do_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
         end
         if (do_misroute && (misroute_cnt_q != 8'hFF)) begin
            misroute_cnt_d = misroute_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge shiftInCLK or negedge resetN) begin
      if (!resetN) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         rx_data_q      <= '0;
         drop_cnt_q     <= '0;
         misroute_cnt_q <= '0;
         overflow_q     <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         rx_data_q      <= rx_data_d;
         drop_cnt_q     <= drop_cnt_d;
         misroute_cnt_q <= misroute_cnt_d;
         overflow_q     <= overflow_d;
      end
   end

   always_ff @(posedge shiftInCLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= bus.shiftInData;
      end
   end

   assign bus.rxData     = rx_data_q;
   assign bus.rxSrc      = rx_data_q[28:26];
   assign bus.rxValid    = is_valid;
   assign bus.rxFull     = is_full;
   assign dropCount      = drop_cnt_q;
   assign misrouteCount  = misroute_cnt_q;
   assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_node_eject_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_node_eject_receiver
//  Purpose  : Self-checking bench for node_eject_receiver. A queue holds the
//             packets expected at the host port; each pop is compared with
//             the queue front, and flags/counters against a small model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_node_eject_receiver;

   localparam logic [2:0] C_NODE_IP = 3'b000;
   localparam int         C_DEPTH   = 4;

   logic       clk;
   logic       resetN;
   logic       clearStats;
   logic [7:0] dropCount;
   logic [7:0] misrouteCount;
   logic       overflow;

   node_eject_receiver_if bus ();

   node_eject_receiver #(
      .NODE_IP    (C_NODE_IP),
      .FIFO_DEPTH (C_DEPTH),
      .ADDR_W     (2)
   ) u_dut (
      .shiftInCLK    (clk),
      .resetN        (resetN),
      .bus           (bus.slave),
      .clearStats    (clearStats),
      .dropCount     (dropCount),
      .misrouteCount (misrouteCount),
      .overflow      (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] exp_q [$];
   int          exp_mis  = 0;
   int          exp_drop = 0;
   logic        exp_ovf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock edge: predict, apply the edge, then compare.
   task automatic step();
      bit pop, loc, acc, drp, mis;
      pop = (exp_q.size() != 0) && bus.rxReady;
      loc = bus.shiftInCS && (bus.shiftInData[31:29] == C_NODE_IP);
      mis = bus.shiftInCS && !loc;
      acc = loc && ((exp_q.size() < C_DEPTH) || pop);
      drp = loc && !acc;
      if (pop) check("pop_data", bus.rxData, exp_q[0]);
      @(posedge clk);
      #1;
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(bus.shiftInData);
      if (clearStats) begin
         exp_mis = 0; exp_drop = 0; exp_ovf = 1'b0;
      end else begin
         if (mis && exp_mis < 255) exp_mis++;
         if (drp) begin
            exp_ovf = 1'b1;
            if (exp_drop < 255) exp_drop++;
         end
      end
      check("valid", 32'(bus.rxValid), 32'(exp_q.size() != 0));
      check("full", 32'(bus.rxFull), 32'(exp_q.size() == C_DEPTH));
      check("misroute_cnt", 32'(misrouteCount), 32'(exp_mis));
      check("drop_cnt", 32'(dropCount), 32'(exp_drop));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (exp_q.size() != 0) begin
         check("head", bus.rxData, exp_q[0]);
         check("src", 32'(bus.rxSrc), 32'(exp_q[0][28:26]));
      end
   endtask

   task automatic send(input logic [31:0] w, input logic rdy);
      bus.shiftInCS   = 1'b1;
      bus.shiftInData = w;
      bus.rxReady     = rdy;
      step();
      bus.shiftInCS   = 1'b0;
   endtask

   task automatic idle(input logic rdy);
      bus.shiftInCS = 1'b0;
      bus.rxReady   = rdy;
      step();
   endtask

   initial begin
      resetN          = 1'b0;
      clearStats      = 1'b0;
      bus.shiftInCS   = 1'b0;
      bus.shiftInData = '0;
      bus.rxReady     = 1'b0;
      #12;
      check("rst_valid", 32'(bus.rxValid), 32'd0);
      check("rst_full", 32'(bus.rxFull), 32'd0);
      check("rst_data", bus.rxData, 32'd0);
      check("rst_src", 32'(bus.rxSrc), 32'd0);
      check("rst_drop", 32'(dropCount), 32'd0);
      check("rst_mis", 32'(misrouteCount), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      resetN = 1'b1;
      @(posedge clk); #1;

      // Single local packet, one-cycle latency, then popped.
      send(32'h1092_4924, 1'b0);
      check("t1_valid", 32'(bus.rxValid), 32'd1);
      check("t1_data", bus.rxData, 32'h1092_4924);
      check("t1_src", 32'(bus.rxSrc), 32'd4);
      idle(1'b1);
      check("t1_empty", 32'(bus.rxValid), 32'd0);
      check("t1_hold", bus.rxData, 32'h1092_4924);

      // Misrouted packet.
      send(32'h4000_0001, 1'b0);
      check("t2_valid", 32'(bus.rxValid), 32'd0);
      check("t2_mis", 32'(misrouteCount), 32'd1);
      check("t2_drop", 32'(dropCount), 32'd0);

      // Five back-to-back with no pops: fourth fills, fifth drops.
      for (int i = 1; i <= 5; i++) begin
         send(32'(i), 1'b0);
         if (i == 4) check("t3_full4", 32'(bus.rxFull), 32'd1);
      end
      check("t3_drop", 32'(dropCount), 32'd1);
      check("t3_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("t3_drained", 32'(bus.rxValid), 32'd0);

      // Full plus same-edge pop: accepted, occupancy unchanged.
      for (int i = 0; i < 4; i++) send(32'h0000_0011 + 32'(i), 1'b0);
      send(32'h0000_00AA, 1'b1);
      check("t4_full", 32'(bus.rxFull), 32'd1);
      check("t4_drop", 32'(dropCount), 32'd1);
      check("t4_head", bus.rxData, 32'h0000_0012);
      for (int i = 0; i < 3; i++) idle(1'b1);
      check("t4_last", bus.rxData, 32'h0000_00AA);
      idle(1'b1);
      check("t4_empty", 32'(bus.rxValid), 32'd0);

      // Saturating misroute count with two packets parked in the FIFO.
      send(32'h0A00_0001, 1'b0);
      send(32'h1400_0002, 1'b0);
      for (int i = 0; i < 260; i++) send(32'hE000_0000 | 32'(i), 1'b0);
      check("t5_sat", 32'(misrouteCount), 32'd255);
      clearStats = 1'b1;
      idle(1'b0);
      clearStats = 1'b0;
      check("t5_clr_mis", 32'(misrouteCount), 32'd0);
      check("t5_clr_drop", 32'(dropCount), 32'd0);
      check("t5_clr_ovf", 32'(overflow), 32'd0);
      check("t5_keep", bus.rxData, 32'h0A00_0001);
      // Clear on the same edge as a misroute: clear wins.
      send(32'h2000_0000, 1'b0);
      clearStats = 1'b1;
      send(32'h2000_0001, 1'b0);
      clearStats = 1'b0;
      check("t5_clr_win", 32'(misrouteCount), 32'd0);

      // Asynchronous reset between edges with two entries buffered.
      check("t6_pre", 32'(exp_q.size()), 32'd2);
      #2;
      resetN = 1'b0;
      #1;
      check("t6_valid", 32'(bus.rxValid), 32'd0);
      check("t6_full", 32'(bus.rxFull), 32'd0);
      check("t6_data", bus.rxData, 32'd0);
      exp_q.delete();
      exp_mis = 0; exp_drop = 0; exp_ovf = 1'b0;
      @(posedge clk); #2;
      resetN = 1'b1;
      @(posedge clk); #1;
      send(32'h0C00_0BEE, 1'b0);
      check("t6_new", bus.rxData, 32'h0C00_0BEE);
      check("t6_src", 32'(bus.rxSrc), 32'd3);
      idle(1'b1);
      check("t6_done", 32'(bus.rxValid), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
